if_id_decode_stage: RTL

- Second pipeline stage of the 32-bit RV32I core. It sits directly downstream of the fetch stage and contains the IF/ID pipeline register, the 32x32 register file, the instruction decoder and immediate generator, and load-use hazard detection.
- It consumes the fetched instruction and its PC. It produces operands, immediate and control for the execute stage.
- It drives pc_write back to fetch; fetch's PC register load is tied to pc_write.

---
 rtl/if_id_decode_stage.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/if_id_decode_stage.sv
// if_id_decode_stage
//   Second stage of the RV32I pipeline: IF/ID register, 32x32 register file
//   with write-first bypass, instruction decoder, immediate generator and
//   load-use hazard detection.
//
// Ports
//   clk, rst            clock (rising edge), async active-low reset
//   instr_in, pc_in     fetched instruction and its address
//   flush               taken branch/jump: discard the IF/ID contents
//   ex_mem_read, ex_rd  load currently in EX and its destination
//   wb_we, wb_rd,       register file write port
//   wb_data
//   pc_write            0 freezes the fetch PC
//   valid_out           decoded instruction is live (not a bubble)
//   pc_out              PC of the decoded instruction
//   rs1_data, rs2_data  register operands
//   imm                 sign-extended immediate
//   rs1, rs2, rd        register fields
//   funct3, funct7b5    instr[14:12], instr[30]
//   reg_write .. jalr   control signals, alu_op (00 add, 01 br, 10 R, 11 I)
//   illegal             unknown opcode in a live slot
module if_id_decode_stage #(
  parameter int          word_size = 32,
  parameter int          reg_count = 32,
  parameter logic [31:0] nop_instr = 32'h0000_0013
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   instr_in,
  input  logic [word_size-1:0]          pc_in,
  input  logic                          flush,
  input  logic                          ex_mem_read,
  input  logic [$clog2(reg_count)-1:0]  ex_rd,
  input  logic                          wb_we,
  input  logic [$clog2(reg_count)-1:0]  wb_rd,
  input  logic [word_size-1:0]          wb_data,
  output logic                          pc_write,
  output logic                          valid_out,
  output logic [word_size-1:0]          pc_out,
  output logic [word_size-1:0]          rs1_data,
  output logic [word_size-1:0]          rs2_data,
  output logic [word_size-1:0]          imm,
  output logic [$clog2(reg_count)-1:0]  rs1,
  output logic [$clog2(reg_count)-1:0]  rs2,
  output logic [$clog2(reg_count)-1:0]  rd,
  output logic [2:0]                    funct3,
  output logic                          funct7b5,
  output logic                          reg_write,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic                          mem_to_reg,
  output logic                          alu_src,
  output logic                          branch,
  output logic                          jump,
  output logic                          jalr,
  output logic [1:0]                    alu_op,
  output logic                          illegal
);

  localparam int idx_w = $clog2(reg_count);

  localparam logic [6:0] op_r      = 7'b0110011;
  localparam logic [6:0] op_i_alu  = 7'b0010011;
  localparam logic [6:0] op_load   = 7'b0000011;
  localparam logic [6:0] op_store  = 7'b0100011;
  localparam logic [6:0] op_branch = 7'b1100011;
  localparam logic [6:0] op_jal    = 7'b1101111;
  localparam logic [6:0] op_jalr   = 7'b1100111;
  localparam logic [6:0] op_lui    = 7'b0110111;
  localparam logic [6:0] op_auipc  = 7'b0010111;

  logic [31:0]          instr;
  logic [word_size-1:0] pc;
  logic                 valid;
  logic                 stall;
  logic [6:0]           opcode;
  logic                 rs1_used;
  logic                 rs2_used;
  logic                 live;

  logic [word_size-1:0] regs [reg_count];

  // IF/ID register: flush beats stall beats load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr <= nop_instr;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= nop_instr;
      valid <= 1'b0;
    end else if (!stall) begin
      instr <= instr_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < reg_count; i++) regs[i] <= '0;
    end else if (wb_we && (wb_rd != '0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  assign opcode   = instr[6:0];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];
  assign pc_out   = pc;

  // Write-first read: a same-cycle write-back to the source wins over the array.
  always_comb begin
    if (rs1 == '0)
      rs1_data = '0;
    else if (wb_we && (wb_rd == rs1))
      rs1_data = wb_data;
    else
      rs1_data = regs[rs1];

    if (rs2 == '0)
      rs2_data = '0;
    else if (wb_we && (wb_rd == rs2))
      rs2_data = wb_data;
    else
      rs2_data = regs[rs2];
  end

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      op_r, op_store, op_branch: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      op_i_alu, op_load, op_jalr: rs1_used = 1'b1;
      default: ;
    endcase
  end

  assign stall = valid && ex_mem_read && (ex_rd != '0) &&
                 (((ex_rd == rs1) && rs1_used) || ((ex_rd == rs2) && rs2_used));

  // A flush reloads fetch from the branch target, so the PC must move even
  // if the discarded instruction would have stalled.
  assign pc_write = !stall || flush;

  assign live      = valid && !stall && !flush;
  assign valid_out = live;

  always_comb begin
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    jalr       = 1'b0;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    imm        = '0;
    case (opcode)
      op_r: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      op_i_alu: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 2'b11;
        imm       = {{20{instr[31]}}, instr[31:20]};
      end
      op_load: begin
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        alu_src    = 1'b1;
        imm        = {{20{instr[31]}}, instr[31:20]};
      end
      op_store: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      op_branch: begin
        branch = 1'b1;
        alu_op = 2'b01;
        imm    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      op_jal: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        jump      = 1'b1;
        imm       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      op_jalr: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        jump      = 1'b1;
        jalr      = 1'b1;
        imm       = {{20{instr[31]}}, instr[31:20]};
      end
      op_lui, op_auipc: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        imm       = {instr[31:12], 12'b0};
      end
      default: illegal = 1'b1;
    endcase

    // Bubble: controls are suppressed, but fields and immediate stay decoded.
    if (!live) begin
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      jalr       = 1'b0;
      alu_op     = 2'b00;
      illegal    = 1'b0;
    end
  end

endmodule
